// File: rtl/vx_axil_ctrl_pkg.sv
// Shared definitions for the Vortex AXI-Lite control block: register map,
// CTRL/STATUS bit positions, run-sequencer states and AXI response codes.
package vx_axil_ctrl_pkg;

  localparam int VX_DCR_ADDR_WIDTH = 12;
  localparam int VX_DCR_DATA_WIDTH = 32;

  // Word offsets, i.e. byte address bits [4:2]
  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_DCR_ADDR  = 3'd1;
  localparam logic [2:0] REG_DCR_DATA  = 3'd2;
  localparam logic [2:0] REG_STATUS    = 3'd3;
  localparam logic [2:0] REG_CYCLES_LO = 3'd4;
  localparam logic [2:0] REG_CYCLES_HI = 3'd5;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_DONE_BIT    = 1;
  localparam int CTRL_IDLE_BIT    = 2;
  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_STATE_LSB = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Byte-lane merge of a write into an existing 32-bit value
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vx_axil_regif.sv
// AXI-Lite slave front end: captures AW and W independently, issues one
// register write/read strobe per transaction and returns registered responses.
module vx_axil_regif
  import vx_axil_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [ADDR_W-1:0] i_awaddr,
  input  logic              i_wvalid,
  output logic              o_wready,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  output logic              o_bvalid,
  input  logic              i_bready,
  output logic [1:0]        o_bresp,
  input  logic              i_arvalid,
  output logic              o_arready,
  input  logic [ADDR_W-1:0] i_araddr,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic [DATA_W-1:0] o_rdata,
  output logic [1:0]        o_rresp,
  output logic              o_wr_en,
  output logic [2:0]        o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [DATA_W/8-1:0] o_wr_strb,
  input  logic [1:0]        i_wr_resp,
  output logic              o_rd_en,
  output logic [2:0]        o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data
);

  logic                r_active;
  logic                r_aw_held;
  logic                r_w_held;
  logic [2:0]          r_aw_addr;
  logic [DATA_W-1:0]   r_w_data;
  logic [DATA_W/8-1:0] r_w_strb;
  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;

  logic w_awready;
  logic w_wready;
  logic w_arready;
  logic w_wr_fire;
  logic w_unused;

  // r_active keeps every ready low while reset is asserted
  assign w_awready = r_active && !r_aw_held && !r_bvalid;
  assign w_wready  = r_active && !r_w_held && !r_bvalid;
  assign w_arready = r_active && !r_rvalid;
  assign w_wr_fire = r_aw_held && r_w_held;
  assign w_unused  = &{1'b0, i_awaddr[ADDR_W-1:5], i_awaddr[1:0],
                       i_araddr[ADDR_W-1:5], i_araddr[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active  <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_active <= 1'b1;
      if (w_wr_fire) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= i_wr_resp;
      end else begin
        if (i_awvalid && w_awready) begin
          r_aw_held <= 1'b1;
          r_aw_addr <= i_awaddr[4:2];
        end
        if (i_wvalid && w_wready) begin
          r_w_held <= 1'b1;
          r_w_data <= i_wdata;
          r_w_strb <= i_wstrb;
        end
        if (r_bvalid && i_bready) r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (i_arvalid && w_arready) begin
      r_rvalid <= 1'b1;
      r_rdata  <= i_rd_data;
    end else if (r_rvalid && i_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign o_awready = w_awready;
  assign o_wready  = w_wready;
  assign o_arready = w_arready;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = r_bresp;
  assign o_rvalid  = r_rvalid;
  assign o_rdata   = r_rdata;
  assign o_rresp   = RESP_OKAY;
  assign o_wr_en   = w_wr_fire;
  assign o_wr_addr = r_aw_addr;
  assign o_wr_data = r_w_data;
  assign o_wr_strb = r_w_strb;
  assign o_rd_en   = i_arvalid && w_arready;
  assign o_rd_addr = i_araddr[4:2];

endmodule

// File: rtl/vx_axil_ctrl.sv
// Host control slave for the Vortex AXI top: DCR programming, kernel
// start/reset sequencing, completion flag/interrupt and a 64-bit run counter.
module vx_axil_ctrl
  import vx_axil_ctrl_pkg::*;
#(
  parameter int AXIL_ADDR_WIDTH = 8,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int RESET_DELAY     = 16,
  parameter int BUSY_WAIT       = 256
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         s_axil_awvalid,
  output logic                         s_axil_awready,
  input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                         s_axil_wvalid,
  output logic                         s_axil_wready,
  input  logic [AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [3:0]                   s_axil_wstrb,
  output logic                         s_axil_bvalid,
  input  logic                         s_axil_bready,
  output logic [1:0]                   s_axil_bresp,
  input  logic                         s_axil_arvalid,
  output logic                         s_axil_arready,
  input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
  output logic                         s_axil_rvalid,
  input  logic                         s_axil_rready,
  output logic [AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]                   s_axil_rresp,
  output logic                         dcr_wr_valid,
  output logic [VX_DCR_ADDR_WIDTH-1:0] dcr_wr_addr,
  output logic [VX_DCR_DATA_WIDTH-1:0] dcr_wr_data,
  output logic                         vx_reset,
  input  logic                         busy,
  output logic                         interrupt
);

  localparam int CNT_MAX = (RESET_DELAY > BUSY_WAIT) ? RESET_DELAY : BUSY_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic        w_wr_en;
  logic [2:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic [1:0]  w_wr_resp;
  logic        w_rd_en;
  logic [2:0]  w_rd_addr;
  logic [31:0] w_rd_data;

  state_t r_state;
  state_t w_state_next;

  logic [31:0]                  r_dcr_addr;
  logic                         r_dcr_wr_valid;
  logic [VX_DCR_ADDR_WIDTH-1:0] r_dcr_wr_addr;
  logic [VX_DCR_DATA_WIDTH-1:0] r_dcr_wr_data;
  logic                         r_vx_reset;
  logic                         r_done_sticky;
  logic                         r_seen_busy;
  logic                         r_busy_q;
  logic [63:0]                  r_cycles;
  logic [31:0]                  r_hi_snap;
  logic [CNT_W-1:0]             r_phase_cnt;

  logic        w_start;
  logic        w_dcr_fire;
  logic        w_enter_run;
  logic [31:0] w_dcr_merged;

  vx_axil_regif #(
    .ADDR_W(AXIL_ADDR_WIDTH),
    .DATA_W(AXIL_DATA_WIDTH)
  ) u_regif (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_awvalid (s_axil_awvalid),
    .o_awready (s_axil_awready),
    .i_awaddr  (s_axil_awaddr),
    .i_wvalid  (s_axil_wvalid),
    .o_wready  (s_axil_wready),
    .i_wdata   (s_axil_wdata),
    .i_wstrb   (s_axil_wstrb),
    .o_bvalid  (s_axil_bvalid),
    .i_bready  (s_axil_bready),
    .o_bresp   (s_axil_bresp),
    .i_arvalid (s_axil_arvalid),
    .o_arready (s_axil_arready),
    .i_araddr  (s_axil_araddr),
    .o_rvalid  (s_axil_rvalid),
    .i_rready  (s_axil_rready),
    .o_rdata   (s_axil_rdata),
    .o_rresp   (s_axil_rresp),
    .o_wr_en   (w_wr_en),
    .o_wr_addr (w_wr_addr),
    .o_wr_data (w_wr_data),
    .o_wr_strb (w_wr_strb),
    .i_wr_resp (w_wr_resp),
    .o_rd_en   (w_rd_en),
    .o_rd_addr (w_rd_addr),
    .i_rd_data (w_rd_data)
  );

  assign w_start      = w_wr_en && (w_wr_addr == REG_CTRL) &&
                        w_wr_strb[0] && w_wr_data[CTRL_START_BIT];
  assign w_dcr_fire   = w_wr_en && (w_wr_addr == REG_DCR_DATA) && (r_state == IDLE);
  assign w_wr_resp    = ((w_wr_addr == REG_DCR_DATA) && (r_state != IDLE)) ?
                        RESP_SLVERR : RESP_OKAY;
  assign w_dcr_merged = apply_strb(r_dcr_wr_data, w_wr_data, w_wr_strb);
  assign w_enter_run  = (r_state == RESET) && (w_state_next == RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (w_start) w_state_next = RESET;
      RESET: if (r_phase_cnt == CNT_W'(RESET_DELAY - 1)) w_state_next = RUN;
      RUN: begin
        // Either busy has come and gone, or it never showed up in time
        if (r_seen_busy && !busy)
          w_state_next = DONE;
        else if (!r_seen_busy && !busy && (r_phase_cnt == CNT_W'(BUSY_WAIT - 1)))
          w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vx_reset    <= 1'b1;
      r_cycles      <= '0;
      r_phase_cnt   <= '0;
      r_seen_busy   <= 1'b0;
      r_done_sticky <= 1'b0;
      r_hi_snap     <= '0;
      r_busy_q      <= 1'b0;
    end else begin
      r_busy_q <= busy;
      if ((r_state == IDLE) && w_start) begin
        r_vx_reset  <= 1'b1;
        r_cycles    <= '0;
        r_phase_cnt <= '0;
      end else if (w_enter_run) begin
        r_vx_reset  <= 1'b0;
        r_phase_cnt <= '0;
        r_seen_busy <= 1'b0;
      end else if (r_state != IDLE) begin
        r_phase_cnt <= r_phase_cnt + CNT_W'(1);
      end
      if (r_state == RUN) begin
        r_cycles <= r_cycles + 64'd1;
        if (busy) r_seen_busy <= 1'b1;
      end
      // The done event takes priority over a clearing read in the same cycle
      if (r_state == DONE)
        r_done_sticky <= 1'b1;
      else if ((r_state == IDLE) && w_start)
        r_done_sticky <= 1'b0;
      else if (w_rd_en && (w_rd_addr == REG_CTRL))
        r_done_sticky <= 1'b0;
      if (w_rd_en && (w_rd_addr == REG_CYCLES_LO)) r_hi_snap <= r_cycles[63:32];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dcr_addr     <= '0;
      r_dcr_wr_valid <= 1'b0;
      r_dcr_wr_addr  <= '0;
      r_dcr_wr_data  <= '0;
    end else begin
      r_dcr_wr_valid <= w_dcr_fire;
      if (w_wr_en && (w_wr_addr == REG_DCR_ADDR))
        r_dcr_addr <= apply_strb(r_dcr_addr, w_wr_data, w_wr_strb);
      if (w_dcr_fire) begin
        r_dcr_wr_addr <= r_dcr_addr[VX_DCR_ADDR_WIDTH-1:0];
        r_dcr_wr_data <= w_dcr_merged;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (w_rd_addr)
      REG_CTRL: begin
        w_rd_data[CTRL_DONE_BIT] = r_done_sticky;
        w_rd_data[CTRL_IDLE_BIT] = (r_state == IDLE);
      end
      REG_DCR_ADDR: w_rd_data = r_dcr_addr;
      REG_STATUS: begin
        w_rd_data[STATUS_BUSY_BIT]       = r_busy_q;
        w_rd_data[STATUS_STATE_LSB +: 2] = r_state;
      end
      REG_CYCLES_LO: w_rd_data = r_cycles[31:0];
      REG_CYCLES_HI: w_rd_data = r_hi_snap;
      default:       w_rd_data = '0;
    endcase
  end

  assign dcr_wr_valid = r_dcr_wr_valid;
  assign dcr_wr_addr  = r_dcr_wr_addr;
  assign dcr_wr_data  = r_dcr_wr_data;
  assign vx_reset     = r_vx_reset;
  assign interrupt    = r_done_sticky;

endmodule

// File: tb/tb_vx_axil_ctrl.sv
// Scenario bench for vx_axil_ctrl: DCR programming, run sequencing, error
// responses, split AW/W handshakes and asynchronous reset recovery.
module tb_vx_axil_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        busy = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        dcr_wr_valid, vx_reset, interrupt;
  logic [11:0] dcr_wr_addr;
  logic [31:0] dcr_wr_data;

  int n_checks = 0;
  int n_fail   = 0;
  int hi_run   = 0;
  int last_hi_len = 0;

  logic [43:0] exp_dcr_q[$];
  logic [31:0] exp_rd_q[$];
  logic [1:0]  exp_resp_q[$];

  always #5 clk = ~clk;

  vx_axil_ctrl #(
    .AXIL_ADDR_WIDTH(8), .AXIL_DATA_WIDTH(32), .RESET_DELAY(16), .BUSY_WAIT(256)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata),
    .s_axil_wstrb(wstrb),
    .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
    .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata),
    .s_axil_rresp(rresp),
    .dcr_wr_valid(dcr_wr_valid), .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data),
    .vx_reset(vx_reset), .busy(busy), .interrupt(interrupt)
  );

  // DCR strobe scoreboard: every pulse must match the oldest expected write
  always @(negedge clk) begin
    if (reset_n && dcr_wr_valid) begin
      logic [43:0] e;
      n_checks++;
      if (exp_dcr_q.size() == 0) begin
        n_fail++;
        $display("FAIL dcr_unexpected: addr=%h data=%h, required no strobe", dcr_wr_addr, dcr_wr_data);
      end else begin
        e = exp_dcr_q.pop_front();
        if ({dcr_wr_addr, dcr_wr_data} !== e) begin
          n_fail++;
          $display("FAIL dcr_payload: got %h_%h, required %h_%h", dcr_wr_addr, dcr_wr_data, e[43:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (vx_reset) hi_run++;
    else begin
      if (hi_run != 0) last_hi_len = hi_run;
      hi_run = 0;
    end
  end

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output bit ok);
    int guard = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while ((awvalid || wvalid) && guard < 50) begin
      logic ah, wh;
      ah = awvalid && awready;
      wh = wvalid && wready;
      @(negedge clk);
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
      guard++;
    end
    while (!bvalid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    ok = bvalid;
    resp = bresp;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output bit ok);
    int guard = 0;
    araddr = a; arvalid = 1'b1;
    while (arvalid && guard < 50) begin
      logic h;
      h = arready;
      @(negedge clk);
      if (h) arvalid = 1'b0;
      guard++;
    end
    while (!rvalid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    ok = rvalid;
    d = rdata;
    arvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_irq(input int limit, output bit ok);
    int t = 0;
    while (!interrupt && t < limit) begin
      @(negedge clk);
      t++;
    end
    ok = interrupt;
  endtask

  task automatic wait_run(output bit ok);
    int t = 0;
    while (vx_reset && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok = !vx_reset;
  endtask

  task automatic test_reset();
    logic [31:0] rd, e;
    bit ok;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid, dcr_wr_valid, interrupt, vx_reset, bresp, rresp, rdata} !== {8'b0000_0001, 4'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b%b%b bv=%b rv=%b dcr=%b irq=%b vxr=%b rdata=%h, required all 0 except vx_reset=1",
               awready, wready, arready, bvalid, rvalid, dcr_wr_valid, interrupt, vx_reset, rdata);
    end
    reset_n = 1'b1;
    @(negedge clk);
    exp_rd_q.push_back(32'h4);
    axi_read(8'h00, rd, ok); e = exp_rd_q.pop_front();
    n_checks++;
    if (!ok || rd !== e) begin n_fail++; $display("FAIL ctrl_after_reset: rdata=%h ok=%0d, required %h", rd, ok, e); end
    exp_rd_q.push_back(32'h0);
    axi_read(8'h0C, rd, ok); e = exp_rd_q.pop_front();
    n_checks++;
    if (!ok || rd !== e || vx_reset !== 1'b1) begin
      n_fail++; $display("FAIL status_after_reset: rdata=%h vx_reset=%b, required %h and 1", rd, vx_reset, e);
    end
  endtask

  task automatic test_dcr();
    logic [31:0] rd, e;
    logic [1:0] resp, er;
    bit ok;
    exp_resp_q.push_back(2'b00);
    axi_write(8'h04, 32'h001, 4'hF, resp, ok); er = exp_resp_q.pop_front();
    n_checks++;
    if (!ok || resp !== er) begin n_fail++; $display("FAIL dcr_addr_wr: bresp=%b ok=%0d, required %b", resp, ok, er); end
    exp_dcr_q.push_back({12'h001, 32'h8000_0000});
    exp_resp_q.push_back(2'b00);
    axi_write(8'h08, 32'h8000_0000, 4'hF, resp, ok); er = exp_resp_q.pop_front();
    n_checks++;
    if (!ok || resp !== er) begin n_fail++; $display("FAIL dcr_data_wr: bresp=%b ok=%0d, required %b", resp, ok, er); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_dcr_q.size() != 0) begin n_fail++; $display("FAIL dcr_pulse_missing: pending=%0d, required 0", exp_dcr_q.size()); end
    exp_resp_q.push_back(2'b00);
    axi_write(8'h04, 32'hAABB_CCDD, 4'b0010, resp, ok); er = exp_resp_q.pop_front();
    exp_rd_q.push_back(32'h0000_CC01);
    axi_read(8'h04, rd, ok); e = exp_rd_q.pop_front();
    n_checks++;
    if (!ok || rd !== e || resp !== er) begin n_fail++; $display("FAIL dcr_addr_strb: rdata=%h bresp=%b, required %h %b", rd, resp, e, er); end
    exp_resp_q.push_back(2'b00);
    axi_write(8'h18, 32'hFFFF_FFFF, 4'hF, resp, ok); er = exp_resp_q.pop_front();
    exp_rd_q.push_back(32'h0);
    axi_read(8'h18, rd, ok); e = exp_rd_q.pop_front();
    n_checks++;
    if (!ok || rd !== e || resp !== er) begin n_fail++; $display("FAIL unmapped: rdata=%h bresp=%b, required %h %b", rd, resp, e, er); end
  endtask

  task automatic test_busy_never();
    logic [31:0] rd, e;
    logic [1:0] resp;
    bit ok;
    axi_write(8'h00, 32'h1, 4'hF, resp, ok);
    wait_irq(600, ok);
    n_checks++;
    if (!ok || resp !== 2'b00) begin n_fail++; $display("FAIL timeout_done: irq=%b bresp=%b, required 1 00", interrupt, resp); end
    exp_rd_q.push_back(32'd256);
    axi_read(8'h10, rd, ok); e = exp_rd_q.pop_front();
    n_checks++;
    if (!ok || rd !== e) begin n_fail++; $display("FAIL timeout_cycles: rdata=%0d, required %0d", rd, e); end
    exp_rd_q.push_back(32'h6);
    axi_read(8'h00, rd, ok); e = exp_rd_q.pop_front();
    n_checks++;
    if (!ok || rd !== e) begin n_fail++; $display("FAIL timeout_ctrl: rdata=%h, required %h", rd, e); end
  endtask

  task automatic test_normal_run();
    logic [31:0] rd, e;
    logic [1:0] resp;
    bit ok;
    axi_write(8'h00, 32'h1, 4'hF, resp, ok);
    n_checks++;
    if (!ok || resp !== 2'b00) begin n_fail++; $display("FAIL start_resp: bresp=%b, required 00", resp); end
    wait_run(ok);
    repeat (5) @(negedge clk);
    busy = 1'b1;
    n_checks++;
    if (!ok || last_hi_len != 16) begin n_fail++; $display("FAIL reset_len: vx_reset high %0d cycles, required 16", last_hi_len); end
    repeat (100) @(negedge clk);
    busy = 1'b0;
    wait_irq(50, ok);
    n_checks++;
    if (!ok || vx_reset !== 1'b0) begin n_fail++; $display("FAIL run_irq: irq=%b vx_reset=%b, required 1 0", interrupt, vx_reset); end
    axi_read(8'h10, rd, ok);
    n_checks++;
    if (!ok || rd < 32'd104 || rd > 32'd106) begin n_fail++; $display("FAIL run_cycles: rdata=%0d, required 105+-1", rd); end
    exp_rd_q.push_back(32'h0);
    axi_read(8'h14, rd, ok); e = exp_rd_q.pop_front();
    n_checks++;
    if (!ok || rd !== e) begin n_fail++; $display("FAIL run_cycles_hi: rdata=%h, required %h", rd, e); end
    exp_rd_q.push_back(32'h6);
    exp_rd_q.push_back(32'h4);
    axi_read(8'h00, rd, ok); e = exp_rd_q.pop_front();
    n_checks++;
    if (!ok || rd !== e) begin n_fail++; $display("FAIL ctrl_done: rdata=%h, required %h", rd, e); end
    axi_read(8'h00, rd, ok); e = exp_rd_q.pop_front();
    n_checks++;
    if (!ok || rd !== e || interrupt !== 1'b0) begin n_fail++; $display("FAIL ctrl_cleared: rdata=%h irq=%b, required %h 0", rd, interrupt, e); end
  endtask

  task automatic test_write_during_run();
    logic [31:0] rd, e;
    logic [1:0] resp, er;
    bit ok;
    axi_write(8'h00, 32'h1, 4'hF, resp, ok);
    wait_run(ok);
    exp_resp_q.push_back(2'b10);
    axi_write(8'h08, 32'hDEAD_BEEF, 4'hF, resp, ok); er = exp_resp_q.pop_front();
    n_checks++;
    if (!ok || resp !== er) begin n_fail++; $display("FAIL run_dcr_slverr: bresp=%b, required %b", resp, er); end
    exp_resp_q.push_back(2'b00);
    axi_write(8'h00, 32'h1, 4'hF, resp, ok); er = exp_resp_q.pop_front();
    n_checks++;
    if (!ok || resp !== er) begin n_fail++; $display("FAIL run_start_okay: bresp=%b, required %b", resp, er); end
    exp_rd_q.push_back(32'h4);
    axi_read(8'h0C, rd, ok); e = exp_rd_q.pop_front();
    n_checks++;
    if (!ok || rd !== e) begin n_fail++; $display("FAIL run_status: rdata=%h, required %h", rd, e); end
    wait_irq(400, ok);
    exp_rd_q.push_back(32'h6);
    axi_read(8'h00, rd, ok); e = exp_rd_q.pop_front();
    n_checks++;
    if (!ok || rd !== e) begin n_fail++; $display("FAIL run_finish: rdata=%h, required %h", rd, e); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] rd, e;
    bit ok;
    int bcnt = 0;
    int stray = 0;
    int guard = 0;
    bready = 1'b0;
    wdata = 32'h123; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    n_checks++;
    if (wready !== 1'b0) begin n_fail++; $display("FAIL w_held: wready=%b, required 0", wready); end
    repeat (2) @(negedge clk);
    awaddr = 8'h04; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    while (!bvalid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    awaddr = 8'h04; wdata = 32'h456; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bvalid) bcnt++;
      if (awready || wready) stray++;
      if (i < 3) @(negedge clk);
    end
    bready = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bcnt != 4 || stray != 0 || bvalid !== 1'b0) begin
      n_fail++; $display("FAIL bvalid_hold: held=%0d stray_ready=%0d bvalid_after=%b, required 4 0 0", bcnt, stray, bvalid);
    end
    exp_rd_q.push_back(32'h123);
    axi_read(8'h04, rd, ok); e = exp_rd_q.pop_front();
    n_checks++;
    if (!ok || rd !== e) begin n_fail++; $display("FAIL single_update: rdata=%h, required %h", rd, e); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd, e;
    logic [1:0] resp;
    bit ok;
    axi_write(8'h00, 32'h1, 4'hF, resp, ok);
    wait_run(ok);
    repeat (20) @(negedge clk);
    rready = 1'b0; araddr = 8'h0C; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    n_checks++;
    if (rvalid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_rvalid: rvalid=%b, required 1", rvalid); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({vx_reset, rvalid, bvalid, interrupt, arready} !== 5'b10000) begin
      n_fail++; $display("FAIL async_reset: vxr/rv/bv/irq/ardy=%b, required 10000", {vx_reset, rvalid, bvalid, interrupt, arready});
    end
    @(negedge clk);
    reset_n = 1'b1; rready = 1'b1;
    @(negedge clk);
    exp_rd_q.push_back(32'h4);
    exp_rd_q.push_back(32'h0);
    axi_read(8'h00, rd, ok); e = exp_rd_q.pop_front();
    n_checks++;
    if (!ok || rd !== e) begin n_fail++; $display("FAIL post_reset_ctrl: rdata=%h, required %h", rd, e); end
    axi_read(8'h10, rd, ok); e = exp_rd_q.pop_front();
    n_checks++;
    if (!ok || rd !== e || vx_reset !== 1'b1) begin n_fail++; $display("FAIL post_reset_cycles: rdata=%h vx_reset=%b, required %h 1", rd, vx_reset, e); end
  endtask

  initial begin
    test_reset();
    test_dcr();
    test_busy_never();
    test_normal_run();
    test_write_during_run();
    test_w_before_aw();
    test_async_reset();
    n_checks++;
    if (exp_dcr_q.size() != 0) begin n_fail++; $display("FAIL dcr_leftover: pending=%0d, required 0", exp_dcr_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
